// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // A fetched pair never straddles an 8-byte boundary.
    function automatic logic [31:0] next_pair_pc(input logic [31:0] pc);
        return pc + (pc[2] ? 32'd4 : 32'd8);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: issues single-outstanding I-cache pair requests and fills inst_fifo,
// flushing on redirects and dropping responses that belong to a squashed request.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_delay,
    input  logic        fifo_full,
    output logic        fifo_rst,
    output logic        delay_rst,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_addr_ok,
    input  logic        icache_data_ok,
    input  logic [31:0] icache_rdata1,
    input  logic [31:0] icache_rdata2,
    output logic        fifo_we1,
    output logic        fifo_we2,
    output logic [31:0] fifo_waddr1,
    output logic [31:0] fifo_waddr2,
    output logic [31:0] fifo_wdata1,
    output logic [31:0] fifo_wdata2,
    output logic [31:0] fetch_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         redirect;
    logic         write_pair;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Redirects are ignored while IDLE so nothing is flushed straight out of reset.
    assign redirect = redirect_valid && (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        icache_req = 1'b0;
        write_pair = 1'b0;

        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
        end

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                icache_req = !fifo_full && !redirect_valid;
                if (icache_req && icache_addr_ok) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = next_pair_pc(fetch_pc_q);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (icache_data_ok) begin
                    write_pair = !redirect;
                    state_d    = FETCH;
                end else if (redirect) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (icache_data_ok) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_rst    = redirect;
        delay_rst   = redirect && redirect_delay;
        icache_addr = icache_req ? word_align(fetch_pc_q) : 32'h0;
        fifo_we1    = write_pair;
        fifo_we2    = write_pair && !req_pc_q[2];
        fifo_waddr1 = write_pair ? req_pc_q : 32'h0;
        fifo_waddr2 = write_pair ? req_pc_q + 32'd4 : 32'h0;
        fifo_wdata1 = write_pair ? icache_rdata1 : 32'h0;
        fifo_wdata2 = write_pair ? icache_rdata2 : 32'h0;
        fetch_pc    = fetch_pc_q;
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: inputs change and outputs are checked in the clock low phase.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_delay;
    logic        fifo_full;
    logic        fifo_rst;
    logic        delay_rst;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] icache_rdata1;
    logic [31:0] icache_rdata2;
    logic        fifo_we1;
    logic        fifo_we2;
    logic [31:0] fifo_waddr1;
    logic [31:0] fifo_waddr2;
    logic [31:0] fifo_wdata1;
    logic [31:0] fifo_wdata2;
    logic [31:0] fetch_pc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_delay (redirect_delay),
        .fifo_full      (fifo_full),
        .fifo_rst       (fifo_rst),
        .delay_rst      (delay_rst),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_addr_ok (icache_addr_ok),
        .icache_data_ok (icache_data_ok),
        .icache_rdata1  (icache_rdata1),
        .icache_rdata2  (icache_rdata2),
        .fifo_we1       (fifo_we1),
        .fifo_we2       (fifo_we2),
        .fifo_waddr1    (fifo_waddr1),
        .fifo_waddr2    (fifo_waddr2),
        .fifo_wdata1    (fifo_wdata1),
        .fifo_wdata2    (fifo_wdata2),
        .fetch_pc       (fetch_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next low phase, leaving time for inputs to be applied before checking.
    task automatic low_phase();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        redirect_delay = 1'b0;
        fifo_full      = 1'b0;
        icache_addr_ok = 1'b0;
        icache_data_ok = 1'b0;
        icache_rdata1  = 32'h0;
        icache_rdata2  = 32'h0;
        settle();
        chk("rst_fetch_pc", fetch_pc, 32'hBFC0_0000);
        chk("rst_req", {31'h0, icache_req}, 32'h0);
        chk("rst_fifo_rst", {31'h0, fifo_rst}, 32'h0);
        chk("rst_we1", {31'h0, fifo_we1}, 32'h0);

        // Reset release: one IDLE cycle with no request.
        low_phase(); rst = 1'b0; settle();
        chk("idle_req", {31'h0, icache_req}, 32'h0);

        // Test 1: first pair from RESET_PC.
        low_phase(); icache_addr_ok = 1'b1; settle();
        chk("t1_req", {31'h0, icache_req}, 32'h1);
        chk("t1_addr", icache_addr, 32'hBFC0_0000);
        low_phase(); icache_addr_ok = 1'b0; settle();
        chk("t1_wait_req", {31'h0, icache_req}, 32'h0);
        chk("t1_fetch_pc", fetch_pc, 32'hBFC0_0008);
        low_phase();
        icache_data_ok = 1'b1; icache_rdata1 = 32'h1111_1111; icache_rdata2 = 32'h2222_2222;
        settle();
        chk("t1_we1", {31'h0, fifo_we1}, 32'h1);
        chk("t1_we2", {31'h0, fifo_we2}, 32'h1);
        chk("t1_waddr1", fifo_waddr1, 32'hBFC0_0000);
        chk("t1_waddr2", fifo_waddr2, 32'hBFC0_0004);
        chk("t1_wdata1", fifo_wdata1, 32'h1111_1111);
        chk("t1_wdata2", fifo_wdata2, 32'h2222_2222);
        low_phase(); icache_data_ok = 1'b0; settle();
        chk("t1_next_addr", icache_addr, 32'hBFC0_0008);

        // Test 2: redirect in FETCH to an odd-word PC (low bits ignored).
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0017; settle();
        chk("t2_fifo_rst", {31'h0, fifo_rst}, 32'h1);
        chk("t2_delay_rst", {31'h0, delay_rst}, 32'h0);
        chk("t2_no_req", {31'h0, icache_req}, 32'h0);
        low_phase(); redirect_valid = 1'b0; icache_addr_ok = 1'b1; settle();
        chk("t2_addr", icache_addr, 32'h8000_0014);
        low_phase(); icache_addr_ok = 1'b0;
        icache_data_ok = 1'b1; icache_rdata1 = 32'h3333_3333; settle();
        chk("t2_we1", {31'h0, fifo_we1}, 32'h1);
        chk("t2_we2", {31'h0, fifo_we2}, 32'h0);
        chk("t2_waddr1", fifo_waddr1, 32'h8000_0014);
        low_phase(); icache_data_ok = 1'b0; settle();
        chk("t2_next_addr", icache_addr, 32'h8000_0018);

        // Test 3: redirect while WAIT, response three cycles later is dropped.
        icache_addr_ok = 1'b1;
        low_phase(); icache_addr_ok = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h9000_0000;
        settle();
        chk("t3_fifo_rst", {31'h0, fifo_rst}, 32'h1);
        chk("t3_we1", {31'h0, fifo_we1}, 32'h0);
        low_phase(); redirect_valid = 1'b0; settle();
        chk("t3_discard_req", {31'h0, icache_req}, 32'h0);
        low_phase(); settle();
        chk("t3_discard_req2", {31'h0, icache_req}, 32'h0);
        low_phase(); icache_data_ok = 1'b1; settle();
        chk("t3_stale_we1", {31'h0, fifo_we1}, 32'h0);
        chk("t3_stale_we2", {31'h0, fifo_we2}, 32'h0);
        low_phase(); icache_data_ok = 1'b0; settle();
        chk("t3_req", {31'h0, icache_req}, 32'h1);
        chk("t3_addr", icache_addr, 32'h9000_0000);

        // Test 4: delay-slot redirect coincident with data_ok.
        icache_addr_ok = 1'b1;
        low_phase(); icache_addr_ok = 1'b0; icache_data_ok = 1'b1;
        redirect_valid = 1'b1; redirect_delay = 1'b1; redirect_pc = 32'hA000_0000; settle();
        chk("t4_fifo_rst", {31'h0, fifo_rst}, 32'h1);
        chk("t4_delay_rst", {31'h0, delay_rst}, 32'h1);
        chk("t4_we1", {31'h0, fifo_we1}, 32'h0);
        chk("t4_we2", {31'h0, fifo_we2}, 32'h0);
        low_phase(); icache_data_ok = 1'b0; redirect_valid = 1'b0; redirect_delay = 1'b0;
        settle();
        chk("t4_fetch_req", {31'h0, icache_req}, 32'h1);
        chk("t4_addr", icache_addr, 32'hA000_0000);

        // Test 5: fifo_full held five cycles blocks issue even with addr_ok high.
        fifo_full = 1'b1; icache_addr_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t5_req_%0d", i), {31'h0, icache_req}, 32'h0);
            chk($sformatf("t5_pc_%0d", i), fetch_pc, 32'hA000_0000);
            low_phase();
        end
        fifo_full = 1'b0; icache_addr_ok = 1'b0; settle();
        chk("t5_req_back", {31'h0, icache_req}, 32'h1);
        chk("t5_addr", icache_addr, 32'hA000_0000);

        // Wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        low_phase(); redirect_valid = 1'b0; icache_addr_ok = 1'b1; settle();
        chk("wrap_addr", icache_addr, 32'hFFFF_FFFC);
        low_phase(); icache_addr_ok = 1'b0; icache_data_ok = 1'b1; settle();
        chk("wrap_fetch_pc", fetch_pc, 32'h0);
        chk("wrap_waddr1", fifo_waddr1, 32'hFFFF_FFFC);
        chk("wrap_waddr2", fifo_waddr2, 32'h0);
        chk("wrap_we2", {31'h0, fifo_we2}, 32'h0);

        // Test 6: async reset mid-WAIT, stale data_ok after release is ignored.
        low_phase(); icache_data_ok = 1'b0; icache_addr_ok = 1'b1; settle();
        chk("t6_addr", icache_addr, 32'h0);
        low_phase(); icache_addr_ok = 1'b0; settle();
        chk("t6_wait_pc", fetch_pc, 32'h8);
        #1 rst = 1'b1; icache_data_ok = 1'b1; settle();
        chk("t6_rst_pc", fetch_pc, 32'hBFC0_0000);
        chk("t6_rst_we1", {31'h0, fifo_we1}, 32'h0);
        chk("t6_rst_req", {31'h0, icache_req}, 32'h0);
        low_phase(); rst = 1'b0; settle();
        chk("t6_stale_we1", {31'h0, fifo_we1}, 32'h0);
        chk("t6_idle_req", {31'h0, icache_req}, 32'h0);
        low_phase(); icache_data_ok = 1'b0; settle();
        chk("t6_req", {31'h0, icache_req}, 32'h1);
        chk("t6_addr", icache_addr, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
